parity_serial_rx: RTL and testbench

- Serial receiver that is the checking end of the team's switch-parity generator.
- Deserialises UART-style frames: start bit, DATA_BITS data bits LSB first, one parity bit, one stop bit.
- Recomputes the XOR parity of the received data, then flags parity and framing errors.
- Sits between a Basys3 input pin (Pmod or USB-UART RX) and LED/display logic; the received byte drives LEDs directly.

---
 rtl/parity_serial_rx.sv | 252 +++++++++++++++++++++++++
 tb/tb_parity_serial_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_serial_rx.sv
// UART-style receiver (start, DATA_BITS LSB-first, parity, stop) that checks XOR parity and stop bit.
// Define PARITY_SERIAL_RX_ERRCNT_EN to add the saturating err_count output.
module parity_serial_rx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int ODD_PARITY   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
`ifdef PARITY_SERIAL_RX_ERRCNT_EN
    output logic [7:0]           err_count,
`endif
    output logic                 busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          ODD_BIT  = (ODD_PARITY != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic exp_parity(input logic [DATA_BITS-1:0] d);
        exp_parity = (^d) ^ ODD_BIT;
    endfunction

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   stop_q, stop_d;
    logic                   done_q, done_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q, busy_d;
`ifdef PARITY_SERIAL_RX_ERRCNT_EN
    logic [7:0]             errcnt_q, errcnt_d;
`endif

    logic cnt_last_s;
    logic cnt_half_s;
    logic idx_last_s;

    assign cnt_last_s = (cnt_q == CNT_LAST);
    assign cnt_half_s = (cnt_q == CNT_HALF);
    assign idx_last_s = (bit_idx_q == IDX_LAST);

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; STOP lingers one extra cycle (done_q) to publish the frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_half_s) begin
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (cnt_last_s && idx_last_s) begin
                    state_d = S_PARITY;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (cnt_last_s) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output/datapath next values: counters, shifter, captured bits and registered outputs.
    always_comb begin
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        stop_d    = stop_q;
        done_d    = 1'b0;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
`ifdef PARITY_SERIAL_RX_ERRCNT_EN
        errcnt_d  = errcnt_q;
`endif
        busy_d    = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                cnt_d     = {CW{1'b0}};
                bit_idx_d = {IW{1'b0}};
            end
            S_START: begin
                bit_idx_d = {IW{1'b0}};
                if (cnt_half_s) begin
                    cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_last_s) begin
                    cnt_d                = {CW{1'b0}};
                    shift_d              = shift_q >> 1;
                    shift_d[DATA_BITS-1] = rx_s_q;
                    if (idx_last_s) begin
                        bit_idx_d = {IW{1'b0}};
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (cnt_last_s) begin
                    cnt_d = {CW{1'b0}};
                    par_d = rx_s_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (done_q) begin
                    cnt_d   = {CW{1'b0}};
                    data_d  = shift_q;
                    perr_d  = (par_q != exp_parity(shift_q));
                    ferr_d  = ~stop_q;
                    valid_d = 1'b1;
`ifdef PARITY_SERIAL_RX_ERRCNT_EN
                    if ((perr_d || ferr_d) && (errcnt_q != 8'hFF)) begin
                        errcnt_d = errcnt_q + 8'd1;
                    end else begin
                        errcnt_d = errcnt_q;
                    end
`endif
                end else if (cnt_last_s) begin
                    cnt_d  = {CW{1'b0}};
                    stop_d = rx_s_q;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d     = {CW{1'b0}};
                bit_idx_d = {IW{1'b0}};
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= {CW{1'b0}};
            bit_idx_q <= {IW{1'b0}};
            shift_q   <= {DATA_BITS{1'b0}};
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= {DATA_BITS{1'b0}};
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef PARITY_SERIAL_RX_ERRCNT_EN
            errcnt_q  <= 8'd0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
`ifdef PARITY_SERIAL_RX_ERRCNT_EN
            errcnt_q  <= errcnt_d;
`endif
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;
`ifdef PARITY_SERIAL_RX_ERRCNT_EN
    assign err_count  = errcnt_q;
`endif

endmodule

// File: tb/tb_parity_serial_rx.sv
// Scoreboard bench for parity_serial_rx: an even-parity and an odd-parity instance share one rx line.
module tb_parity_serial_rx;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic [7:0] ec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_e, data_o;
    logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;
`ifdef PARITY_SERIAL_RX_ERRCNT_EN
    logic [7:0] errcnt_e, errcnt_o;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   vcount   = 0;
    int   vstamp[$];
    exp_t q_even[$];
    exp_t q_odd[$];
    int   err_model = 0;
    logic pend_e = 1'b0;
    logic pend_o = 1'b0;

    parity_serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .ODD_PARITY(0)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data_e), .valid(valid_e),
        .parity_err(perr_e), .frame_err(ferr_e),
`ifdef PARITY_SERIAL_RX_ERRCNT_EN
        .err_count(errcnt_e),
`endif
        .busy(busy_e)
    );

    parity_serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rst(rst), .rx(rx), .data(data_o), .valid(valid_o),
        .parity_err(perr_o), .frame_err(ferr_o),
`ifdef PARITY_SERIAL_RX_ERRCNT_EN
        .err_count(errcnt_o),
`endif
        .busy(busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Even-parity instance scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (pend_e) begin
            check_eq("valid_pulse_e", {31'd0, valid_e}, 32'd0);
            pend_e = 1'b0;
        end
        if (valid_e) begin
            vcount++;
            vstamp.push_back(cyc);
            pend_e = 1'b1;
            if (q_even.size() == 0) begin
                check_eq("spurious_valid_e", 32'd1, 32'd0);
            end else begin
                e = q_even.pop_front();
                check_eq("data_e", {24'd0, data_e}, {24'd0, e.d});
                check_eq("perr_e", {31'd0, perr_e}, {31'd0, e.pe});
                check_eq("ferr_e", {31'd0, ferr_e}, {31'd0, e.fe});
`ifdef PARITY_SERIAL_RX_ERRCNT_EN
                check_eq("err_count", {24'd0, errcnt_e}, {24'd0, e.ec});
`endif
            end
        end
    end

    // Odd-parity instance scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (pend_o) begin
            check_eq("valid_pulse_o", {31'd0, valid_o}, 32'd0);
            pend_o = 1'b0;
        end
        if (valid_o) begin
            pend_o = 1'b1;
            if (q_odd.size() == 0) begin
                check_eq("spurious_valid_o", 32'd1, 32'd0);
            end else begin
                e = q_odd.pop_front();
                check_eq("data_o", {24'd0, data_o}, {24'd0, e.d});
                check_eq("perr_o", {31'd0, perr_o}, {31'd0, e.pe});
                check_eq("ferr_o", {31'd0, ferr_o}, {31'd0, e.fe});
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
        exp_t e;
        e.d  = d;
        e.fe = ~sb;
        e.pe = (pb != (^d));
        if ((e.pe || e.fe) && err_model < 255) err_model++;
        e.ec = 8'(err_model);
        q_even.push_back(e);
        e.pe = (pb != ~(^d));
        e.ec = 8'd0;
        q_odd.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(pb);
        drive_bit(sb);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input int n, input int budget);
        int k;
        k = 0;
        while (vcount < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("valid_wait", {31'd0, (vcount >= n)}, 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_data"}, {24'd0, data_e}, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, valid_e}, 32'd0);
        check_eq({tag, "_perr"}, {31'd0, perr_e}, 32'd0);
        check_eq({tag, "_ferr"}, {31'd0, ferr_e}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy_e}, 32'd0);
`ifdef PARITY_SERIAL_RX_ERRCNT_EN
        check_eq({tag, "_errcnt"}, {24'd0, errcnt_e}, 32'd0);
`endif
    endtask

    initial begin
        int   base;
        int   vc0;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Clean frame, even ones count.
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_valid(1, 12);
        @(negedge clk);
        check_eq("busy_after_valid", {31'd0, busy_e}, 32'd0);

        // Parity mismatch for even, match for odd.
        send_frame(8'h07, 1'b0, 1'b1);
        wait_valid(2, 12);

        // Bad stop bit.
        send_frame(8'hFF, 1'b0, 1'b0);
        wait_valid(3, 12);
        repeat (4) @(posedge clk);
        #1;

        // One-cycle glitch while idle.
        vc0 = vcount;
        seen = 1'b0;
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | busy_e;
        end
        check_eq("glitch_busy_seen", {31'd0, seen}, 32'd1);
        check_eq("glitch_busy_low", {31'd0, busy_e}, 32'd0);
        check_eq("glitch_no_valid", vcount, vc0);
        @(posedge clk);
        #1;

        // Back-to-back frames.
        base = vstamp.size();
        send_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b1);
        wait_valid(base + 2, 12);
        if (vstamp.size() >= base + 2) begin
            check_eq("b2b_gap", vstamp[base+1] - vstamp[base], 32'd44);
        end
        repeat (4) @(posedge clk);
        #1;

        // Reset in the middle of the data bits of 0x55.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        check_eq("mid_frame_busy", {31'd0, busy_e}, 32'd1);
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        rx = 1'b1;
        err_model = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vc0 = vcount;
        repeat (60) @(posedge clk);
        #1;
        check_eq("no_valid_after_rst", vcount, vc0);

        send_frame(8'h81, 1'b0, 1'b1);
        wait_valid(vc0 + 1, 12);
        repeat (4) @(posedge clk);
        check_eq("queue_drained", q_even.size() + q_odd.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
